// File: rtl/wb_master_seq.sv
// Wishbone classic-cycle self-test master: writes an arithmetic pattern over a
// contiguous slave range, reads it back, and reports failures on ports.
module wb_master_seq #(
  parameter int BASE_ADDRESS = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_COUNT   = 16,
  parameter int AU_IN_DATA   = 1,
  parameter logic [DATA_WIDTH-1:0] PATTERN_SEED = '0,
  parameter logic [DATA_WIDTH-1:0] PATTERN_STEP = DATA_WIDTH'(32'h1111_1111),
  parameter int TIMEOUT      = 255,
  localparam int CNT_WIDTH   = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic                  timeout,
  output logic [CNT_WIDTH+1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] err_adr,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WREQ  = 3'd1;
  localparam logic [2:0] S_WWAIT = 3'd2;
  localparam logic [2:0] S_RREQ  = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]         TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST    = CNT_WIDTH'(DATA_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(AU_IN_DATA);

  logic [2:0]            state;
  logic                  mode_r, start_old;
  logic [CNT_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] pat;
  logic [ADDR_WIDTH-1:0] adr;
  logic [TW-1:0]         tcnt;
  logic                  waiting, term, to_hit, fail;

  // pat/adr track pat(idx)/addr(idx) incrementally alongside the index
  always_comb begin
    waiting = (state == S_WWAIT) || (state == S_RWAIT);
    term    = waiting && (ack_i || err_i);
    to_hit  = waiting && !term && (TIMEOUT != 0) && (tcnt == TO_LAST);
    fail    = to_hit || (term && (err_i || ((state == S_RWAIT) && (dat_i != pat))));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mode_r    <= 1'b0;
      start_old <= 1'b0;
      idx       <= '0;
      pat       <= '0;
      adr       <= '0;
      tcnt      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      err_adr   <= '0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
    end else begin
      start_old <= start;
      if (fail) begin
        error <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!error) err_adr <= adr_o;
      end
      case (state)
        S_IDLE: begin
          if (!start && start_old) begin
            state     <= S_WREQ;
            mode_r    <= mode;
            idx       <= '0;
            pat       <= PATTERN_SEED;
            adr       <= BASE;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            err_adr   <= '0;
          end
        end
        S_WREQ: begin
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          we_o  <= 1'b1;
          dat_o <= pat;
          adr_o <= adr;
          tcnt  <= '0;
          state <= S_WWAIT;
        end
        S_RREQ: begin
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          we_o  <= 1'b0;
          adr_o <= adr;
          tcnt  <= '0;
          state <= S_RWAIT;
        end
        S_WWAIT, S_RWAIT: begin
          if (term || to_hit) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
          end
          if (to_hit) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_IDLE;
          end else if (!term) begin
            tcnt <= tcnt + 1'b1;
          end else if (state == S_WWAIT) begin
            if (!mode_r) begin
              state <= S_RREQ;
            end else if (idx == LAST) begin
              // block mode: rewind to word 0 for the read-back pass
              idx   <= '0;
              pat   <= PATTERN_SEED;
              adr   <= BASE;
              state <= S_RREQ;
            end else begin
              idx   <= idx + 1'b1;
              pat   <= pat + PATTERN_STEP;
              adr   <= adr + STRIDE;
              state <= S_WREQ;
            end
          end else if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            idx   <= idx + 1'b1;
            pat   <= pat + PATTERN_STEP;
            adr   <= adr + STRIDE;
            state <= mode_r ? S_RREQ : S_WREQ;
          end
        end
        default: begin
          state <= S_IDLE;
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// Scoreboard bench for wb_master_seq against a zero-wait RAM slave with
// fault injection (read corruption, err_i, never-ack).
module tb_wb_master_seq;
  localparam int DW = 32, AW = 16, N = 16;
  localparam int BASE = 'h100, AU = 4, TO = 8;

  logic clk = 1'b0;
  logic rst, start, mode, done, busy, error, timeout;
  logic cyc_o, stb_o, we_o, ack_i, err_i;
  logic [5:0] err_count;
  logic [AW-1:0] err_adr, adr_o;
  logic [DW-1:0] dat_o, dat_i;

  always #5 clk = ~clk;

  wb_master_seq #(.BASE_ADDRESS(BASE), .AU_IN_DATA(AU), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .done(done), .busy(busy),
    .error(error), .timeout(timeout), .err_count(err_count), .err_adr(err_adr),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i));

  // slave: combinational ack, optional corruption / err_i / hang on word 3 write
  logic [DW-1:0] mem [N];
  logic [3:0] widx;
  logic corrupt = 1'b0, hang = 1'b0, fill_req = 1'b0;
  int err_w = -1, err_r = -1;

  assign widx = 4'((adr_o - 16'(BASE)) >> 2);

  always_comb begin
    err_i = cyc_o && stb_o && ((we_o && int'(widx) == err_w) || (!we_o && int'(widx) == err_r));
    ack_i = cyc_o && stb_o && !err_i && !(hang && we_o && widx == 4'd3);
    dat_i = mem[widx] ^ ((corrupt && widx == 4'd5) ? 32'h0000_0100 : 32'h0);
  end

  always @(posedge clk) begin
    if (fill_req) for (int i = 0; i < N; i++) mem[i] <= 32'hDEAD_0000 | i;
    else if (cyc_o && stb_o && we_o && ack_i) mem[widx] <= dat_o;
  end

  typedef struct { logic we; logic [AW-1:0] adr; logic [DW-1:0] dat; } xfer_t;
  typedef struct { int lat; logic err; logic to; logic [5:0] cnt; logic [AW-1:0] eadr; } res_t;
  xfer_t exp_q[$];
  res_t  res_q[$];
  int checks = 0, failures = 0;
  int cyc_n = 0, det = 0, hang_cnt = 0;
  logic done_q = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] a_of(int i); return AW'(BASE + i * AU); endfunction
  function automatic logic [DW-1:0] p_of(int i); return DW'(i) * 32'h1111_1111; endfunction

  task automatic push_xfer(logic we, int i);
    xfer_t x;
    x.we = we; x.adr = a_of(i); x.dat = we ? p_of(i) : '0;
    exp_q.push_back(x);
  endtask

  task automatic push_run(logic m, int nw);
    if (!m) begin
      for (int i = 0; i < nw; i++) begin push_xfer(1'b1, i); push_xfer(1'b0, i); end
    end else begin
      for (int i = 0; i < nw; i++) push_xfer(1'b1, i);
      if (nw == N) for (int i = 0; i < N; i++) push_xfer(1'b0, i);
    end
  endtask

  task automatic push_res(int lat, logic e, logic t, logic [5:0] c, logic [AW-1:0] a);
    res_t r;
    r.lat = lat; r.err = e; r.to = t; r.cnt = c; r.eadr = a;
    res_q.push_back(r);
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // monitor: pops an expected transfer on every bus termination, a result on done rising
  always @(negedge clk) begin
    xfer_t x;
    res_t r;
    if (rst && cyc_o && stb_o && (ack_i || err_i)) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL xfer_extra: got we=%0b adr=0x%0h, required no transfer", we_o, adr_o);
      end else begin
        x = exp_q.pop_front();
        chk("xfer_we", 64'(we_o), 64'(x.we));
        chk("xfer_adr", 64'(adr_o), 64'(x.adr));
        if (x.we) chk("xfer_dat", 64'(dat_o), 64'(x.dat));
      end
    end
    if (rst && done && !done_q) begin
      if (res_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_extra: got done=1, required no completion");
      end else begin
        r = res_q.pop_front();
        if (r.lat >= 0) chk("done_latency", 64'(cyc_n - det), 64'(r.lat));
        chk("error", 64'(error), 64'(r.err));
        chk("timeout", 64'(timeout), 64'(r.to));
        chk("err_count", 64'(err_count), 64'(r.cnt));
        chk("err_adr", 64'(err_adr), 64'(r.eadr));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("xfers_left", 64'(exp_q.size()), 64'(0));
      end
    end
    done_q <= done;
    if (cyc_o && we_o && hang && adr_o == a_of(3)) hang_cnt <= hang_cnt + 1;
  end

  task automatic fill();
    @(negedge clk) fill_req = 1'b1;
    @(negedge clk) fill_req = 1'b0;
  endtask

  task automatic do_start(logic m);
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; det = cyc_n + 1;
    @(negedge clk);
  endtask

  task automatic wait_done(int max, string name);
    int n = 0;
    while (!done && n < max) begin @(negedge clk); n++; end
    chk({name, "_done_seen"}, 64'(done), 64'(1));
    repeat (2) @(negedge clk);
    chk({name, "_results_left"}, 64'(res_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, required finish");
    $fatal(1);
  end

  initial begin
    int h0, n;
    rst = 1'b0; start = 1'b0; mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", 64'(cyc_o), 64'(0));
    chk("rst_stb", 64'(stb_o), 64'(0));
    chk("rst_we", 64'(we_o), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_flags", 64'({error, timeout, err_count, err_adr}), 64'(0));
    chk("rst_adr_dat", 64'({adr_o, dat_o}), 64'(0));
    rst = 1'b1;
    fill();

    // interleaved run; an extra start pulse mid-run must be ignored
    push_run(1'b0, N); push_res(64, 1'b0, 1'b0, 6'd0, 16'h0);
    do_start(1'b0);
    chk("busy_in_run", 64'(busy), 64'(1));
    repeat (20) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(200, "mode0");

    // block mode
    fill();
    push_run(1'b1, N); push_res(64, 1'b0, 1'b0, 6'd0, 16'h0);
    do_start(1'b1);
    wait_done(200, "mode1");

    // read corruption of word 5
    fill(); corrupt = 1'b1;
    push_run(1'b0, N); push_res(64, 1'b1, 1'b0, 6'd1, 16'h0114);
    do_start(1'b0);
    wait_done(200, "corrupt");
    corrupt = 1'b0;

    // err_i on both write and read of word 2
    fill(); err_w = 2; err_r = 2;
    push_run(1'b0, N); push_res(64, 1'b1, 1'b0, 6'd2, 16'h0108);
    do_start(1'b0);
    wait_done(200, "bus_err");
    err_w = -1; err_r = -1;

    // never-acked write of word 3 times out after 8 wait cycles
    fill(); hang = 1'b1; h0 = hang_cnt;
    push_run(1'b0, 3); push_res(21, 1'b1, 1'b1, 6'd1, 16'h010C);
    do_start(1'b0);
    wait_done(200, "timeout");
    chk("timeout_wait_cycles", 64'(hang_cnt - h0), 64'(8));
    chk("timeout_cyc_low", 64'(cyc_o), 64'(0));
    hang = 1'b0;

    // rerun clears all flags at the start edge
    fill();
    push_run(1'b0, N); push_res(64, 1'b0, 1'b0, 6'd0, 16'h0);
    do_start(1'b0);
    chk("rerun_cleared", 64'({done, error, timeout, err_count}), 64'(0));
    wait_done(200, "rerun");

    // async reset while stuck in WRITE_WAIT
    fill(); hang = 1'b1;
    push_run(1'b1, 3);
    do_start(1'b1);
    n = 0;
    while (!(cyc_o && we_o && adr_o == a_of(3)) && n < 100) begin @(negedge clk); n++; end
    chk("reach_word3", 64'(cyc_o && we_o), 64'(1));
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_bus", 64'({cyc_o, stb_o, we_o}), 64'(0));
    chk("arst_done_busy", 64'({done, busy}), 64'(0));
    chk("arst_xfers_left", 64'(exp_q.size()), 64'(0));
    @(negedge clk); rst = 1'b1; hang = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 64'({cyc_o, busy, done}), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
Parametrised Wishbone classic-cycle test master. It generates an arithmetic data pattern, writes it to a contiguous slave address range, and reads it back for verification. It supports interleaved and block (write-all-then-read-all) modes and handles the err_i bus-error response. An ack timeout aborts the run. Results are reported on ports (error flag, counters, first failing address) instead of simulation stops, so the block can serve as a synthesizable built-in self-test on any Wishbone slave in the library.

Parameters:
BASE_ADDRESS, 0, address of word 0 on the slave.
DATA_WIDTH, 32, width of dat_o/dat_i.
ADDR_WIDTH, 16, width of adr_o.
DATA_COUNT, 16, words per run (>=1).
AU_IN_DATA, 1, addressable units per word; address stride.
PATTERN_SEED, 0, value of word 0.
PATTERN_STEP, 32'h11111111, per-word increment, truncated to DATA_WIDTH.
TIMEOUT, 255, max wait-state cycles per transfer; 0 disables the timeout.
CNT_WIDTH (localparam), $clog2(DATA_COUNT) (min 1), index width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active low.
start  in  1  a falling edge (1 then 0 on consecutive samples) starts a run.
mode  in  1  0 = interleaved write/read per word; 1 = block mode. Sampled at the start edge.
done  out  1  high from run completion until the next start edge.
busy  out  1  high while a run is in progress.
error  out  1  sticky; any mismatch, err_i or timeout in the current run.
timeout  out  1  sticky; the run was aborted by a timeout.
err_count  out  CNT_WIDTH+2  failure count; saturates at all-ones.
err_adr  out  ADDR_WIDTH  address of the first failure in the run.
cyc_o  out  1  Wishbone cycle.
stb_o  out  1  Wishbone strobe.
we_o  out  1  1 = write, 0 = read.
adr_o  out  ADDR_WIDTH  transfer address.
dat_o  out  DATA_WIDTH  write data.
dat_i  in  DATA_WIDTH  read data.
ack_i  in  1  slave acknowledge.
err_i  in  1  slave bus-error termination.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, including cyc_o/stb_o/we_o, mid-transfer. Index, timeout counter and start_old are 0.
- Pattern: pat(i) = (PATTERN_SEED + i*PATTERN_STEP) mod 2^DATA_WIDTH.
- Address: addr(i) = (BASE_ADDRESS + i*AU_IN_DATA) mod 2^ADDR_WIDTH.
- start_old registers start every cycle.
- Start edge while busy=1 is ignored.
- IDLE: on start=0 and start_old=1, go to WRITE_REQ. In the same edge: latch mode; index=0; busy=1; clear done, error, timeout, err_count, err_adr.
- WRITE_REQ (1 cycle): set cyc_o=stb_o=we_o=1, dat_o=pat(index), adr_o=addr(index); go to WRITE_WAIT.
- WRITE_WAIT: bus outputs hold until termination. Termination is ack_i or err_i sampled high.
  - On termination: drop cyc_o/stb_o/we_o.
  - err_i counts as a failure; if both ack_i and err_i are high, err_i wins.
  - Next state, mode 0: READ_REQ, same index.
  - Next state, mode 1: if index=DATA_COUNT-1, set index=0 and go to READ_REQ; otherwise index+1 and WRITE_REQ.
- READ_REQ (1 cycle): set cyc_o=stb_o=1, we_o=0, adr_o=addr(index); dat_o holds. Go to READ_WAIT.
- READ_WAIT: on ack_i (without err_i), compare dat_i with pat(index); inequality is a failure. err_i is a failure with no compare.
  - If index=DATA_COUNT-1: go to IDLE, busy=0, done=1.
  - Otherwise: index+1, then WRITE_REQ (mode 0) or READ_REQ (mode 1).
- Failure accounting: error=1 and err_count increments (saturating). If this is the first failure of the run, err_adr=adr_o of the failing transfer.
- Timeout: counter clears on entry to each WAIT state and increments each WAIT cycle without termination. When TIMEOUT!=0 and the counter reaches TIMEOUT:
  - drop cyc_o/stb_o/we_o;
  - set timeout=1; record a failure;
  - busy=0, done=1; go to IDLE (run aborted).
- Latency with a zero-wait slave (ack in the first WAIT cycle): each transfer takes 2 cycles. done rises at edge 4*DATA_COUNT after the detecting edge in both modes (64 for defaults).
- Index wraps only via the explicit last-word checks. It never exceeds DATA_COUNT-1.
- An illegal state encoding recovers to IDLE with bus outputs low.

Test Plan:
1. Defaults, mode 0, zero-wait RAM slave, pulse start 1→0 → alternating W/R at adr 0..15. Writes carry 0x00000000..0xFFFFFFFF. done=1 at edge 64 after detection; error=0, err_count=0.
2. Mode 1, same slave → 16 writes at adr 0..15, then 16 reads at adr 0..15. done at edge 64; no errors.
3. Slave corrupts the read of word 5 (AU_IN_DATA=4, BASE_ADDRESS=0x100) → run completes; error=1, err_count=1, err_adr=0x114.
4. Slave asserts err_i on the write of word 2 and again on its read → err_count=2, err_adr=addr(2); run completes with done=1.
5. TIMEOUT=8, slave never acks word 3 → cyc_o drops after 8 wait cycles; timeout=1, error=1, done=1, busy=0. A new start edge clears all flags and reruns.
6. rst low mid-WRITE_WAIT → cyc_o/stb_o/we_o/done/busy go 0 immediately. Start edge during busy has no effect.
